// File: rtl/fma16_pkg.sv
// Shared constants for the binary16 FMA pack stage: rounding modes, flag
// positions, binary16 encodings, the control state enum and the rounding rule.
package fma16_pkg;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RM  = 2'b10;
    localparam logic [1:0] RP  = 2'b11;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam int          BIAS      = 15;
    localparam logic [14:0] MAXFINITE = 15'h7BFF;
    localparam logic [14:0] INF       = 15'h7C00;
    localparam logic [15:0] QNAN      = 16'h7E00;

    // The all-ones exponent field (2*BIAS+1) is reserved, so reaching it overflows.
    localparam logic signed [8:0] EXP_OVF = 9'(2 * BIAS + 1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    function automatic logic round_up(
        input logic [1:0] mode,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       sticky
    );
        logic up;
        case (mode)
            RNE:     up = guard & (sticky | lsb);
            RP:      up = ~sign & (guard | sticky);
            RM:      up = sign & (guard | sticky);
            default: up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/fma16_round.sv
// Combinational rounder and packer for a normalized binary16 sum.
// FMA16_SUBNORM_EN selects gradual underflow; without it tiny results flush to zero.
module fma16_round
    import fma16_pkg::*;
(
    input  logic              sign,
    input  logic signed [8:0] expo,
    input  logic [32:0]       mag,
    input  logic              sticky,
    input  logic              nan,
    input  logic              inf,
    input  logic              invalid,
    input  logic [1:0]        roundmode,
    output logic [15:0]       result,
    output logic [3:0]        flags
);

    logic [10:0]       sig;
    logic              guard;
    logic              sticky_all;
    logic              inc;
    logic [11:0]       sum;
    logic [10:0]       rsig;
    logic signed [8:0] rexp;
    logic              hidden;
    logic              tiny;
    logic              inexact;
    logic              overflow;
    logic [4:0]        exp_field;

    // A carry out of the 11-bit significand can only come from 0x7FF, so the
    // bit dropped by the renormalizing shift is always zero.
    always_comb begin
        sig        = mag[32:22];
        guard      = mag[21];
        sticky_all = (|mag[20:0]) | sticky;
        inc        = round_up(roundmode, sign, sig[0], guard, sticky_all);
        sum        = {1'b0, sig} + {11'd0, inc};
        if (sum[11]) begin
            rsig = sum[11:1];
            rexp = expo + 9'sd1;
        end else begin
            rsig = sum[10:0];
            rexp = expo;
        end
        hidden    = rsig[10];
        tiny      = ~hidden;
        inexact   = guard | sticky_all;
        overflow  = hidden && (rexp >= EXP_OVF);
        exp_field = hidden ? rexp[4:0] : 5'd0;
    end

    always_comb begin
        result = 16'h0000;
        flags  = 4'b0000;
        if (nan) begin
            result              = QNAN;
            flags[FLAG_INVALID] = invalid;
        end else if (inf) begin
            result              = {sign, INF};
            flags[FLAG_INVALID] = invalid;
        end else if (mag == 33'd0 && !sticky) begin
            result = {sign, 15'd0};
        end else if (overflow) begin
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
            case (roundmode)
                RNE:     result = {sign, INF};
                RZ:      result = {sign, MAXFINITE};
                RP:      result = sign ? {1'b1, MAXFINITE} : {1'b0, INF};
                default: result = sign ? {1'b1, INF} : {1'b0, MAXFINITE};
            endcase
`ifdef FMA16_SUBNORM_EN
        end else begin
            result                = {sign, exp_field, rsig[9:0]};
            flags[FLAG_UNDERFLOW] = tiny & inexact;
            flags[FLAG_INEXACT]   = inexact;
        end
`else
        // Nonzero input here guarantees a nonzero rounded value or inexact.
        end else if (tiny) begin
            result                = {sign, 15'd0};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            result              = {sign, exp_field, rsig[9:0]};
            flags[FLAG_INEXACT] = inexact;
        end
`endif
    end

endmodule

// File: rtl/fma16_pack.sv
// Iterative normalize/round/pack back end for the binary16 FMA, with valid/ready
// handshakes on both sides. FMA16_SUBNORM_EN enables gradual underflow (else FTZ).
module fma16_pack
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Ss,
    input  logic [6:0]  Se,
    input  logic [33:0] Sm,
    input  logic        sticky_in,
    input  logic        nan_in,
    input  logic        inf_in,
    input  logic        invalid_in,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  flags
);

    state_t            state;
    logic              sign_r;
    logic signed [8:0] exp_r;
    logic [33:0]       mag_r;
    logic              sticky_r;
    logic              acc_r;
    logic              nan_r;
    logic              inf_r;
    logic              invalid_r;
    logic [1:0]        mode_r;
    logic              shift_right;
    logic              shift_left;
    logic [15:0]       rnd_result;
    logic [3:0]        rnd_flags;

    // Exponent is carried two bits wider than the input so that shifting a
    // large or very negative Se never wraps.
    always_comb begin
        shift_right = mag_r[33] || (exp_r < 9'sd1 && mag_r != 34'd0);
        shift_left  = !mag_r[32] && mag_r != 34'd0 && exp_r > 9'sd1;
    end

    fma16_round u_round (
        .sign      (sign_r),
        .expo      (exp_r),
        .mag       (mag_r[32:0]),
        .sticky    (acc_r | sticky_r),
        .nan       (nan_r),
        .inf       (inf_r),
        .invalid   (invalid_r),
        .roundmode (mode_r),
        .result    (rnd_result),
        .flags     (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= 16'h0000;
            flags     <= 4'b0000;
            sign_r    <= 1'b0;
            exp_r     <= 9'sd0;
            mag_r     <= 34'd0;
            sticky_r  <= 1'b0;
            acc_r     <= 1'b0;
            nan_r     <= 1'b0;
            inf_r     <= 1'b0;
            invalid_r <= 1'b0;
            mode_r    <= RZ;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r    <= Ss;
                        exp_r     <= {{2{Se[6]}}, Se};
                        mag_r     <= Sm;
                        sticky_r  <= sticky_in;
                        acc_r     <= 1'b0;
                        nan_r     <= nan_in;
                        inf_r     <= inf_in;
                        invalid_r <= invalid_in;
                        mode_r    <= roundmode;
                        in_ready  <= 1'b0;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (nan_r || inf_r) begin
                        state <= ROUND;
                    end else if (shift_right) begin
                        mag_r <= mag_r >> 1;
                        acc_r <= acc_r | mag_r[0];
                        exp_r <= exp_r + 9'sd1;
                    end else if (shift_left) begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 9'sd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result    <= rnd_result;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
